// File: rtl/ej1_input_conditioner_if.sv
// ej1_input_conditioner_if
//   Raw request inputs and conditioned outputs of the I/S input conditioner.
//   master : drives the raw switch/button levels and consumes the conditioned
//            levels and strobes (board/testbench side).
//   slave  : the conditioner itself.
//   Signals:
//     i_raw, s_raw     raw asynchronous I / S requests
//     I, S             debounced, synchronized levels (feed the ej1b FSM)
//     i_pulse, s_pulse one-cycle strobes on accepted rising edges
interface ej1_input_conditioner_if;
  logic i_raw;
  logic s_raw;
  logic I;
  logic S;
  logic i_pulse;
  logic s_pulse;

  modport master (
    output i_raw, s_raw,
    input  I, S, i_pulse, s_pulse
  );

  modport slave (
    input  i_raw, s_raw,
    output I, S, i_pulse, s_pulse
  );
endinterface

// File: rtl/ej1_input_conditioner.sv
// ej1_input_conditioner
//   Two independent, identical channels (lane 0 = I, lane 1 = S). Each lane
//   synchronizes its raw input through two flops, then debounces it with a
//   4-state FSM: a new level must be seen on DEBOUNCE_CYCLES consecutive
//   synchronized cycles before it is accepted. Raw level to output latency
//   is DEBOUNCE_CYCLES+2 rising edges.
//   Parameters:
//     DEBOUNCE_CYCLES  cycles a new level must hold (1..255)
//     CNT_W            debounce counter width, must hold DEBOUNCE_CYCLES-1
//   Ports:
//     clk    system clock, rising edge
//     reset  asynchronous, active-high
//     bus    slave side of ej1_input_conditioner_if
module ej1_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  ej1_input_conditioner_if.slave  bus
);

  localparam int NUM_LANES = 2;

  // Terminal count: the FSM spends one cycle entering the WAIT state, then
  // counts 0..DEBOUNCE_CYCLES-2 while the new level holds. With a single
  // cycle of debounce the WAIT states are bypassed entirely.
  localparam bit              ONE_CYCLE = (DEBOUNCE_CYCLES == 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    (DEBOUNCE_CYCLES >= 2) ? CNT_W'(DEBOUNCE_CYCLES - 2) : '0;

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_RISE_WAIT = 2'd1,
    ST_HIGH      = 2'd2,
    ST_FALL_WAIT = 2'd3
  } lane_state_e;

  logic [NUM_LANES-1:0] raw;
  logic [NUM_LANES-1:0] lvl;
  logic [NUM_LANES-1:0] pulse;

  assign raw         = {bus.s_raw, bus.i_raw};
  assign bus.I       = lvl[0];
  assign bus.S       = lvl[1];
  assign bus.i_pulse = pulse[0];
  assign bus.s_pulse = pulse[1];

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic              sync1;
    logic              sync2;
    lane_state_e       st;
    logic [CNT_W-1:0]  cnt;
    logic              pls;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync1 <= 1'b0;
        sync2 <= 1'b0;
        st    <= ST_LOW;
        cnt   <= '0;
        pls   <= 1'b0;
      end else begin
        sync1 <= raw[g];
        sync2 <= sync1;
        pls   <= 1'b0;
        unique case (st)
          ST_LOW: begin
            if (sync2) begin
              cnt <= '0;
              if (ONE_CYCLE) begin
                st  <= ST_HIGH;
                pls <= 1'b1;
              end else begin
                st  <= ST_RISE_WAIT;
              end
            end
          end
          ST_RISE_WAIT: begin
            if (!sync2) begin
              st  <= ST_LOW;
              cnt <= '0;
            end else if (cnt == CNT_LAST) begin
              // Rising acceptance: the strobe lands in the first cycle the
              // level output reads 1.
              st  <= ST_HIGH;
              cnt <= '0;
              pls <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_HIGH: begin
            if (!sync2) begin
              cnt <= '0;
              st  <= ONE_CYCLE ? ST_LOW : ST_FALL_WAIT;
            end
          end
          ST_FALL_WAIT: begin
            // Returning to HIGH after a low glitch is not a new rising edge,
            // so no strobe on that path.
            if (sync2) begin
              st  <= ST_HIGH;
              cnt <= '0;
            end else if (cnt == CNT_LAST) begin
              st  <= ST_LOW;
              cnt <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            st  <= ST_LOW;
            cnt <= '0;
          end
        endcase
      end
    end

    // Level is a pure decode of registered state: no path from the raw pin.
    assign lvl[g]   = (st == ST_HIGH) || (st == ST_FALL_WAIT);
    assign pulse[g] = pls;
  end

endmodule

// File: tb/tb_ej1_input_conditioner.sv
module tb_ej1_input_conditioner;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  ej1_input_conditioner_if ifc ();
  ej1_input_conditioner_if ifc1 ();

  ej1_input_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  ej1_input_conditioner #(.DEBOUNCE_CYCLES(1), .CNT_W(8)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc1)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Raw inputs held high through reset: outputs stay 0, and after release
  // the first strobe appears only on edge 6.
  task automatic test_reset;
    logic [3:0] exp;
    logic [3:0] got;
    reset = 1'b1;
    ifc.i_raw = 1'b1;  ifc.s_raw = 1'b1;
    ifc1.i_raw = 1'b0; ifc1.s_raw = 1'b0;
    repeat (3) step();
    got = {ifc.I, ifc.S, ifc.i_pulse, ifc.s_pulse};
    n_tests++;
    if (got !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_hold got %b want 0000", got);
    end
    got = {ifc1.I, ifc1.S, ifc1.i_pulse, ifc1.s_pulse};
    n_tests++;
    if (got !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_hold_d1 got %b want 0000", got);
    end
    reset = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      exp = {(k >= 6), (k >= 6), (k == 6), (k == 6)};
      got = {ifc.I, ifc.S, ifc.i_pulse, ifc.s_pulse};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL reset_release edge %0d got %b want %b", k, got, exp);
      end
    end
    ifc.i_raw = 1'b0; ifc.s_raw = 1'b0;
    repeat (6) step();
    got = {ifc.I, ifc.S, ifc.i_pulse, ifc.s_pulse};
    n_tests++;
    if (got !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_drop got %b want 0000", got);
    end
  endtask

  // I rises on edge 6 with a single strobe, S untouched.
  task automatic test_rise;
    logic [3:0] exp;
    logic [3:0] got;
    do_reset();
    ifc.i_raw = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      exp = {(k >= 6), (k == 6), 1'b0, 1'b0};
      got = {ifc.I, ifc.i_pulse, ifc.S, ifc.s_pulse};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL rise edge %0d got %b want %b", k, got, exp);
      end
    end
  endtask

  // Fall after 6 edges with no strobe; then a 2-cycle low glitch is ignored.
  task automatic test_fall;
    logic [1:0] exp;
    logic [1:0] got;
    ifc.i_raw = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      exp = {(k < 6), 1'b0};
      got = {ifc.I, ifc.i_pulse};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL fall edge %0d got %b want %b", k, got, exp);
      end
    end
    ifc.i_raw = 1'b1;
    repeat (6) step();
    n_tests++;
    if (ifc.I !== 1'b1) begin
      n_fail++;
      $display("FAIL fall_rehigh got %b want 1", ifc.I);
    end
    ifc.i_raw = 1'b0;
    step();
    step();
    ifc.i_raw = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      got = {ifc.I, ifc.i_pulse};
      n_tests++;
      if (got !== 2'b10) begin
        n_fail++;
        $display("FAIL low_glitch edge %0d got %b want 10", k, got);
      end
    end
  endtask

  // 3-cycle high glitch from LOW is rejected; a following hold then needs
  // the full 6-edge latency, showing the counter restarted from 0.
  task automatic test_glitch;
    logic [1:0] exp;
    logic [1:0] got;
    ifc.i_raw = 1'b0;
    repeat (6) step();
    n_tests++;
    if (ifc.I !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_setup got %b want 0", ifc.I);
    end
    ifc.i_raw = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      if (k == 4) ifc.i_raw = 1'b0;
      step();
      got = {ifc.I, ifc.i_pulse};
      n_tests++;
      if (got !== 2'b00) begin
        n_fail++;
        $display("FAIL high_glitch edge %0d got %b want 00", k, got);
      end
    end
    ifc.i_raw = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      exp = {(k >= 6), (k == 6)};
      got = {ifc.I, ifc.i_pulse};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL post_glitch edge %0d got %b want %b", k, got, exp);
      end
    end
  endtask

  // Both raw inputs rise between the same edges: levels and strobes coincide.
  task automatic test_simultaneous;
    logic [3:0] exp;
    logic [3:0] got;
    ifc.i_raw = 1'b0; ifc.s_raw = 1'b0;
    repeat (6) step();
    ifc.i_raw = 1'b1; ifc.s_raw = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      exp = {(k >= 6), (k >= 6), (k == 6), (k == 6)};
      got = {ifc.I, ifc.S, ifc.i_pulse, ifc.s_pulse};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL simultaneous edge %0d got %b want %b", k, got, exp);
      end
    end
    ifc.i_raw = 1'b0; ifc.s_raw = 1'b0;
    repeat (6) step();
  endtask

  // Reset between edges in RISE_WAIT (cnt=2) discards the pending rise; a
  // still-high input requalifies in 6 edges. Reset while the strobe is high
  // clears I and i_pulse without waiting for a clock edge.
  task automatic test_async_reset;
    logic [1:0] exp;
    logic [1:0] got;
    ifc.i_raw = 1'b1;
    repeat (5) step();
    #2;
    reset = 1'b1;
    #1;
    got = {ifc.I, ifc.i_pulse};
    n_tests++;
    if (got !== 2'b00) begin
      n_fail++;
      $display("FAIL async_rst_wait got %b want 00", got);
    end
    step();
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      exp = {(k >= 6), (k == 6)};
      got = {ifc.I, ifc.i_pulse};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL requalify edge %0d got %b want %b", k, got, exp);
      end
    end
    #2;
    reset = 1'b1;
    #1;
    got = {ifc.I, ifc.i_pulse};
    n_tests++;
    if (got !== 2'b00) begin
      n_fail++;
      $display("FAIL async_rst_high got %b want 00", got);
    end
    step();
    ifc.i_raw = 1'b0;
    reset = 1'b0;
  endtask

  // DEBOUNCE_CYCLES=1: rise after 3 edges with one strobe, fall after 3.
  task automatic test_one_cycle;
    logic [2:0] exp;
    logic [2:0] got;
    ifc1.i_raw = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      exp = {(k >= 3), (k == 3), 1'b0};
      got = {ifc1.I, ifc1.i_pulse, ifc1.S};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL d1_rise edge %0d got %b want %b", k, got, exp);
      end
    end
    ifc1.i_raw = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      exp = {(k < 3), 1'b0, 1'b0};
      got = {ifc1.I, ifc1.i_pulse, ifc1.S};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL d1_fall edge %0d got %b want %b", k, got, exp);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    ifc.i_raw = 1'b0;  ifc.s_raw = 1'b0;
    ifc1.i_raw = 1'b0; ifc1.s_raw = 1'b0;
    test_reset();
    test_rise();
    test_fall();
    test_glitch();
    test_simultaneous();
    test_async_reset();
    test_one_cycle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ej1_input_conditioner.md
EJ1_INPUT_CONDITIONER -- requirements
Module: ej1_input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, is the number of consecutive synchronized cycles a new level must hold before it is accepted; legal range 1..255.
REQ-002 Parameter CNT_W, default 8, is the debounce counter width; it SHALL hold DEBOUNCE_CYCLES-1.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 i_raw  input  1  raw asynchronous I request (switch/button).
REQ-006 s_raw  input  1  raw asynchronous S request (switch/button).
REQ-007 I  output  1  debounced, synchronized I level; drives the downstream ej1b FSM.
REQ-008 S  output  1  debounced, synchronized S level; drives the downstream ej1b FSM.
REQ-009 i_pulse  output  1  one-cycle strobe on each accepted rising edge of I.
REQ-010 s_pulse  output  1  one-cycle strobe on each accepted rising edge of S.

Function
REQ-011 Each channel (I, S) SHALL be an independent, identical instance of the logic in REQ-012..REQ-020; there is no interaction between channels.
REQ-012 Each raw input SHALL pass through a 2-flop synchronizer (sync1 then sync2); only sync2 feeds downstream logic.
REQ-013 Per-channel FSM states: LOW, RISE_WAIT, HIGH, FALL_WAIT; plus one counter cnt of width CNT_W.
REQ-014 LOW: sync2=1 -> RISE_WAIT with cnt<=0, except DEBOUNCE_CYCLES=1 -> HIGH directly; sync2=0 -> stay.
REQ-015 RISE_WAIT: sync2=0 -> LOW, cnt<=0; sync2=1 and cnt=DEBOUNCE_CYCLES-2 -> HIGH, cnt<=0; otherwise cnt<=cnt+1.
REQ-016 HIGH and FALL_WAIT SHALL mirror REQ-014/REQ-015 with levels inverted (HIGH -> FALL_WAIT -> LOW).
REQ-017 Level output SHALL be 1 in HIGH and FALL_WAIT and 0 in LOW and RISE_WAIT, decoded from registered state (no raw-input path).
REQ-018 Latency: a raw level held constant SHALL change the level output after exactly DEBOUNCE_CYCLES+2 rising edges, counted from the first edge that samples it into sync1.
REQ-019 A synchronized glitch shorter than DEBOUNCE_CYCLES cycles SHALL cause no output change and SHALL return the FSM to its prior stable state with cnt=0.
REQ-020 Pulse outputs SHALL be registered and high for exactly one cycle, in the same cycle the level output first reads 1 after a LOW->HIGH acceptance; no pulse on falling acceptance.
REQ-021 Simultaneous I and S changes SHALL be accepted on the same edge when their sync2 histories are identical.
REQ-022 cnt SHALL never exceed DEBOUNCE_CYCLES-2 and SHALL never wrap.

Reset
REQ-023 While reset=1: sync1, sync2, cnt cleared; FSM=LOW; I=S=0; i_pulse=s_pulse=0; this holds regardless of clk.
REQ-024 Reset asserted mid-debounce SHALL discard the pending transition; after release, a still-high raw input SHALL requalify with full DEBOUNCE_CYCLES+2 latency.
REQ-025 Raw inputs high during reset release SHALL NOT produce a pulse earlier than DEBOUNCE_CYCLES+2 edges after release.

Verification (DEBOUNCE_CYCLES=4)
REQ-026 Reset, then i_raw 0->1 held -> I=1 after the 6th rising edge; i_pulse=1 for that one cycle only; S=0, s_pulse=0 throughout.
REQ-027 i_raw high for 3 synchronized cycles, then low -> I stays 0, i_pulse never asserts, FSM back in LOW with cnt=0.
REQ-028 I stable 1, i_raw 1->0 held -> I=0 after 6 edges, no pulse; then a 2-cycle low glitch while I=1 -> I remains 1.
REQ-029 i_raw and s_raw rise between the same pair of edges -> I and S rise on the same edge; i_pulse and s_pulse coincide for one cycle.
REQ-030 Reset asserted asynchronously (between edges) during RISE_WAIT with cnt=2 -> I, i_pulse, cnt go 0 immediately; after release with i_raw still 1 -> I=1 exactly 6 edges later.
REQ-031 DEBOUNCE_CYCLES=1 build: i_raw 0->1 -> I=1 after 3 edges, one i_pulse.
